// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core: default datapath widths and
// the architectural zero register address.
package mips_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/popcount.sv
// Counts the set bits of a vector; used for the scoreboard occupancy count.
module popcount #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 6
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] cnt_o
);
  logic [OUT_W-1:0] cnt_s;

  // Ripple sum of every input bit.
  always_comb begin
    cnt_s = {OUT_W{1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      cnt_s = cnt_s + OUT_W'(in_i[i]);
    end
  end

  assign cnt_o = cnt_s;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two writeback ports, same-cycle read bypass and a
// per-register load scoreboard for operand hazard detection in decode.
module reg_file_sb #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NRD*ADDR_W-1:0] i_raddr,
  output logic [NRD*DATA_W-1:0] o_rdata,
  output logic [NRD-1:0]        o_rbusy,
  input  logic                  i_we0,
  input  logic [ADDR_W-1:0]     i_waddr0,
  input  logic [DATA_W-1:0]     i_wdata0,
  input  logic                  i_we1,
  input  logic [ADDR_W-1:0]     i_waddr1,
  input  logic [DATA_W-1:0]     i_wdata1,
  input  logic                  i_bset,
  input  logic [ADDR_W-1:0]     i_baddr,
  output logic [ADDR_W:0]       o_busy_cnt
);
  import mips_pkg::*;

  localparam int                NREG    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR   = ADDR_W'(REG_ZERO);
  localparam bit                ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]     mem_q [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [ADDR_W:0]       busy_cnt_q, busy_cnt_d;
  logic                  we0_s, we1_s, bset_s;
  logic [NRD*DATA_W-1:0] rdata_s;
  logic [NRD-1:0]        rbusy_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == ZADDR);
  endfunction

  // Qualified write/set strobes: anything aimed at the zero register is dropped.
  always_comb begin
    we0_s  = i_we0  && !is_zero(i_waddr0);
    we1_s  = i_we1  && !is_zero(i_waddr1);
    bset_s = i_bset && !is_zero(i_baddr);
  end

  // Scoreboard next state; a new load issue outranks a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int a = 0; a < NREG; a++) begin
      if (bset_s && (i_baddr == ADDR_W'(a))) begin
        busy_d[a] = 1'b1;
      end else if (we1_s && (i_waddr1 == ADDR_W'(a))) begin
        busy_d[a] = 1'b0;
      end else begin
        busy_d[a] = busy_q[a];
      end
    end
  end

  popcount #(
    .IN_W  (NREG),
    .OUT_W (ADDR_W + 1)
  ) u_popcount (
    .in_i  (busy_d),
    .cnt_o (busy_cnt_d)
  );

  // Storage, scoreboard and count; port 1 is written last so it wins collisions.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      busy_q     <= {NREG{1'b0}};
      busy_cnt_q <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (we0_s) begin
        mem_q[i_waddr0] <= i_wdata0;
      end
      if (we1_s) begin
        mem_q[i_waddr1] <= i_wdata1;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Read ports with write bypass; the load writeback also bypasses its busy clear.
  always_comb begin
    rdata_s = {(NRD * DATA_W){1'b0}};
    rbusy_s = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      logic [ADDR_W-1:0] ra_s;
      ra_s = i_raddr[k*ADDR_W +: ADDR_W];
      if (i_rst || is_zero(ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rbusy_s[k]                  = 1'b0;
      end else if (i_we1 && (i_waddr1 == ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = i_wdata1;
        rbusy_s[k]                  = 1'b0;
      end else if (i_we0 && (i_waddr0 == ra_s)) begin
        rdata_s[k*DATA_W +: DATA_W] = i_wdata0;
        rbusy_s[k]                  = busy_q[ra_s];
      end else begin
        rdata_s[k*DATA_W +: DATA_W] = mem_q[ra_s];
        rbusy_s[k]                  = busy_q[ra_s];
      end
    end
  end

  assign o_rdata    = rdata_s;
  assign o_rbusy    = rbusy_s;
  assign o_busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed hand-computed cases followed by
// randomized traffic compared every cycle against an array-based model.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [NR*AW-1:0] i_raddr = '0;
  logic [NR*DW-1:0] o_rdata;
  logic [NR-1:0]  o_rbusy;
  logic           i_we0 = 1'b0, i_we1 = 1'b0, i_bset = 1'b0;
  logic [AW-1:0]  i_waddr0 = '0, i_waddr1 = '0, i_baddr = '0;
  logic [DW-1:0]  i_wdata0 = '0, i_wdata1 = '0;
  logic [AW:0]    o_busy_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] mdl_mem [32];
  logic          mdl_busy [32];

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .o_rbusy(o_rbusy), .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
    .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1),
    .i_bset(i_bset), .i_baddr(i_baddr), .o_busy_cnt(o_busy_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: plain arrays updated by the architectural write/scoreboard rules.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        mdl_mem[i]  <= '0;
        mdl_busy[i] <= 1'b0;
      end
    end else begin
      if (i_we0 && i_waddr0 != 0) mdl_mem[i_waddr0] <= i_wdata0;
      if (i_we1 && i_waddr1 != 0) mdl_mem[i_waddr1] <= i_wdata1;
      if (i_we1 && i_waddr1 != 0) mdl_busy[i_waddr1] <= 1'b0;
      if (i_bset && i_baddr != 0) mdl_busy[i_baddr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (i_rst || a == 0) return '0;
    if (i_we1 && i_waddr1 == a) return i_wdata1;
    if (i_we0 && i_waddr0 == a) return i_wdata0;
    return mdl_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (i_rst || a == 0) return 1'b0;
    if (i_we1 && i_waddr1 == a) return 1'b0;
    return mdl_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    if (i_rst) return 0;
    for (int i = 0; i < 32; i++) c += int'(mdl_busy[i]);
    return c;
  endfunction

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge i_clk) begin
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("cmp_rdata%0d", k), o_rdata[k*DW +: DW], exp_data(i_raddr[k*AW +: AW]));
      chk($sformatf("cmp_rbusy%0d", k), DW'(o_rbusy[k]), DW'(exp_busy(i_raddr[k*AW +: AW])));
    end
    chk("cmp_busy_cnt", DW'(o_busy_cnt), DW'(exp_cnt()));
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_we0 = 1'b0; i_we1 = 1'b0; i_bset = 1'b0;
  endtask

  task automatic rd(input int p0, input int p1);
    i_raddr[0 +: AW]  = AW'(p0);
    i_raddr[AW +: AW] = AW'(p1);
  endtask

  initial begin
    // Reset held: reads, bypass and writes all suppressed.
    tick();
    i_we0 = 1'b1; i_waddr0 = 5'd3; i_wdata0 = 32'hDEAD;
    rd(3, 3);
    #1;
    chk("rst_bypass_off", o_rdata[0 +: DW], 32'h0);
    tick();
    idle();
    i_rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(2 * a, 2 * a + 1);
      #1;
      chk("post_rst_rdata0", o_rdata[0 +: DW], 32'h0);
      chk("post_rst_rdata1", o_rdata[DW +: DW], 32'h0);
      chk("post_rst_rbusy", DW'(o_rbusy), 32'h0);
      chk("post_rst_cnt", DW'(o_busy_cnt), 32'h0);
      tick();
    end

    // Write-then-read and bypass.
    i_we0 = 1'b1; i_waddr0 = 5'd12; i_wdata0 = 32'h48; rd(12, 0);
    #1; chk("bypass_r12", o_rdata[0 +: DW], 32'h48);
    tick();
    i_waddr0 = 5'd6; i_wdata0 = 32'h6c; rd(12, 6);
    #1; chk("stored_r12", o_rdata[0 +: DW], 32'h48);
    chk("bypass_r6", o_rdata[DW +: DW], 32'h6c);
    tick(); idle();
    #1; chk("stored_r6", o_rdata[DW +: DW], 32'h6c);

    // Collision on r3 and writes to r0.
    tick();
    i_we0 = 1'b1; i_waddr0 = 5'd3; i_wdata0 = 32'h2d8;
    i_we1 = 1'b1; i_waddr1 = 5'd3; i_wdata1 = 32'h111; rd(3, 0);
    #1; chk("collide_bypass", o_rdata[0 +: DW], 32'h111);
    tick(); idle();
    #1; chk("collide_stored", o_rdata[0 +: DW], 32'h111);
    tick();
    i_we0 = 1'b1; i_waddr0 = 5'd0; i_wdata0 = 32'hFFFF;
    i_we1 = 1'b1; i_waddr1 = 5'd0; i_wdata1 = 32'h1234; rd(0, 0);
    #1; chk("r0_bypass", o_rdata[0 +: DW], 32'h0);
    tick(); idle();
    #1; chk("r0_stored", o_rdata[0 +: DW], 32'h0);

    // Scoreboard set and bypassed clear.
    tick();
    i_bset = 1'b1; i_baddr = 5'd5; rd(5, 5);
    #1; chk("bset_not_bypassed", DW'(o_rbusy), 32'h0);
    tick(); idle();
    #1; chk("r5_busy", DW'(o_rbusy), 32'h3);
    chk("cnt_one", DW'(o_busy_cnt), 32'h1);
    i_we1 = 1'b1; i_waddr1 = 5'd5; i_wdata1 = 32'hABCD;
    #1; chk("clear_bypass", DW'(o_rbusy), 32'h0);
    chk("load_bypass", o_rdata[0 +: DW], 32'hABCD);
    chk("cnt_still_one", DW'(o_busy_cnt), 32'h1);
    tick(); idle();
    #1; chk("cnt_zero", DW'(o_busy_cnt), 32'h0);

    // Set/clear race on r7, and set on r0.
    i_bset = 1'b1; i_baddr = 5'd7; i_we1 = 1'b1; i_waddr1 = 5'd7; i_wdata1 = 32'h77;
    tick(); idle(); rd(7, 0);
    #1; chk("race_set_wins", DW'(o_rbusy), 32'h1);
    chk("race_cnt", DW'(o_busy_cnt), 32'h1);
    i_bset = 1'b1; i_baddr = 5'd0;
    tick(); idle();
    #1; chk("r0_never_busy", DW'(o_rbusy), 32'h1);
    chk("r0_cnt_same", DW'(o_busy_cnt), 32'h1);
    i_we1 = 1'b1; i_waddr1 = 5'd7; i_wdata1 = 32'h70;
    tick(); idle();

    // Asynchronous reset between edges.
    i_we0 = 1'b1; i_waddr0 = 5'd9; i_wdata0 = 32'h55; i_bset = 1'b1; i_baddr = 5'd4;
    tick(); idle(); rd(9, 4);
    #1; chk("pre_rst_r9", o_rdata[0 +: DW], 32'h55);
    chk("pre_rst_r4busy", DW'(o_rbusy), 32'h2);
    i_rst = 1'b1;
    #1; chk("async_rdata", o_rdata[0 +: DW], 32'h0);
    chk("async_rbusy", DW'(o_rbusy), 32'h0);
    chk("async_cnt", DW'(o_busy_cnt), 32'h0);
    tick(); i_rst = 1'b0;
    #1; chk("after_rst_r9", o_rdata[0 +: DW], 32'h0);
    chk("after_rst_r4", DW'(o_rbusy), 32'h0);
    tick();

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 1500; n++) begin
      i_rst    = ($urandom_range(0, 99) == 0);
      i_we0    = $urandom_range(0, 1);
      i_we1    = $urandom_range(0, 2) == 0;
      i_bset   = $urandom_range(0, 2) == 0;
      i_waddr0 = AW'($urandom_range(0, 31));
      i_waddr1 = ($urandom_range(0, 3) == 0) ? i_waddr0 : AW'($urandom_range(0, 31));
      i_baddr  = ($urandom_range(0, 3) == 0) ? i_waddr1 : AW'($urandom_range(0, 31));
      i_wdata0 = $urandom;
      i_wdata1 = $urandom;
      rd($urandom_range(0, 31), ($urandom_range(0, 2) == 0) ? int'(i_waddr1) : $urandom_range(0, 31));
      tick();
    end
    i_rst = 1'b0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
